l1_cache_array_bank: RTL
========================

Name: l1_cache_array_bank

Overview:
Parametrised successor L1 data/tag/state array for the rv64g L1 controller.
- Generalises sets, ways, line size and tag width.
- Registered one-cycle read.
- Separate data and metadata write ports.
- Write-first bypass.
- Integrated tag compare producing a one-hot hit vector.
- State is cleared by a sequential per-set sweep engine, not by resetting every array flop, so the arrays can map onto SRAM macros.

Parameters:
- SETS, 32, number of sets; power of two, ≥2.
- WAYS, 8, associativity; power of two, ≥2.
- LINE_BYTES, 64, bytes per line; multiple of 8.
- TAG_W, 53, tag width in bits.
- Derived localparams: INDEX_W=clog2(SETS), WORD_W=clog2(LINE_BYTES/8), WAY_W=clog2(WAYS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- inv_all_i  in  1  pulse; start an invalidate sweep
- busy_o  out  1  sweep in progress
- req_valid_i  in  1  read/lookup request
- req_index_i  in  INDEX_W  set index
- req_word_i  in  WORD_W  64-bit word within the line
- req_tag_i  in  TAG_W  lookup tag
- data_we_i  in  1  data word write enable
- meta_we_i  in  1  tag/state write enable
- wr_index_i  in  INDEX_W  write set
- wr_word_i  in  WORD_W  write word
- wr_way_i  in  WAY_W  write way
- wr_be_i  in  8  byte enables
- wr_data_i  in  64  write data
- wr_tag_i  in  TAG_W  tag to write
- wr_state_i  in  2  MESI state to write
- rvalid_o  out  1  read outputs valid
- rdata_way_flat_o  out  WAYS*64  per-way data word
- tag_way_flat_o  out  WAYS*TAG_W  per-way tag
- state_way_flat_o  out  WAYS*2  per-way state
- hit_way_o  out  WAYS  one-hot hit vector
- hit_o  out  1  OR-reduction of hit_way_o

Behaviour:
- Reset:
  - FSM enters SWEEP with sweep_cnt=0 and busy_o=1.
  - rvalid_o, hit_o and hit_way_o are 0.
  - The flat output registers reset to 0.
  - Data and tag arrays are not reset.
- FSM IDLE:
  - inv_all_i=1 → SWEEP with sweep_cnt=0; busy_o=1 from the next cycle.
- FSM SWEEP:
  - Each cycle, write MESI_N to the state of all ways of set sweep_cnt, then increment.
  - After set SETS-1 is written → IDLE.
  - busy_o is high for exactly SETS cycles.
- During SWEEP:
  - req_valid_i, data_we_i, meta_we_i and inv_all_i are ignored.
  - rvalid_o=0.
  - inv_all_i in the same cycle as the final sweep step is also ignored.
- Reset asserted mid-sweep: FSM restarts from sweep_cnt=0.
- Read, IDLE only:
  - req_valid_i at cycle N → rvalid_o=1 at N+1.
  - Outputs at N+1 hold {data[w][index,word], tag[w][index], state[w][index]} for every way w.
  - Outputs hold their value while rvalid_o=0.
- Hit: hit_way_o[w] = (state[w] != MESI_N) && (tag[w] == req_tag_i). It is registered with the data and is 0 whenever rvalid_o=0.
- Data write, IDLE:
  - Byte-masked read-modify-write of data[wr_way][wr_index,wr_word].
  - Byte b is written only if wr_be_i[b]=1.
  - wr_be_i=0 leaves the word unchanged.
- Meta write, IDLE: tag[wr_way][wr_index] ← wr_tag_i and state[wr_way][wr_index] ← wr_state_i. Independent of data_we_i.
- Same-cycle read and write (write-first bypass):
  - If the read index equals wr_index, outputs for way wr_way reflect the post-write values.
  - Data is bypassed only when the word also matches, using the merged bytes.
  - Hit evaluation uses the bypassed tag and state.
- Timing: all array updates take effect at the clock edge, and a read in the following cycle sees them.

Decomposition:
- l1_pkg (params.vh) holds MESI_N/B/T/TT encodings, DATA_W=64, and a common clog2 function.
- One sub-module, l1_tag_cmp: combinational per-way tag/state compare producing a one-hot hit vector. It is reusable by the L1 controller's snoop path.

Test Plan:
- Release reset → busy_o=1 for 32 cycles, then 0; read of any set gives state_way_flat_o=0 and hit_o=0.
- Meta write way3/set5, tag=0x1234, state=MESI_T; data write word2, be=0xFF, data=0xDEADBEEF_CAFEF00D; next cycle read set5/word2/tag 0x1234 → rvalid_o=1 at N+1, hit_way_o=8'h08, way-3 data matches.
- Write be=0x0F with data 0x11111111_22222222 over the prior word → way-3 word reads 0xDEADBEEF_22222222.
- Same-cycle meta write way1/set7, tag 0xAB, MESI_B plus read set7 with tag 0xAB → hit_way_o=8'h02 on the next cycle.
- inv_all_i pulse after filling several sets → busy_o high 32 cycles, req_valid_i ignored (rvalid_o=0), subsequent lookups miss.
- Assert rst_ni low at sweep cycle 10, release → busy_o high a full 32 cycles again.

Source files
------------

// File: rtl/l1_pkg.sv
// l1_pkg: shared L1 array encodings, widths and helpers.
package l1_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        MESI_N  = 2'b00,
        MESI_B  = 2'b01,
        MESI_T  = 2'b10,
        MESI_TT = 2'b11
    } mesi_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } fsm_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
        return r;
    endfunction

endpackage

// File: rtl/l1_tag_cmp.sv
// l1_tag_cmp: per-way tag/state compare giving a one-hot hit vector.
module l1_tag_cmp
    import l1_pkg::*;
#(
    parameter int WAYS  = 8,
    parameter int TAG_W = 53
) (
    input  logic [WAYS*TAG_W-1:0] tag_way_flat_i,
    input  logic [WAYS*2-1:0]     state_way_flat_i,
    input  logic [TAG_W-1:0]      tag_i,
    output logic [WAYS-1:0]       hit_way_o
);

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign hit_way_o[w] = (state_way_flat_i[2*w +: 2] != MESI_N) &&
                              (tag_way_flat_i[TAG_W*w +: TAG_W] == tag_i);
    end

endmodule

// File: rtl/l1_cache_array_bank.sv
// l1_cache_array_bank: L1 data/tag/state arrays with registered read,
// write-first bypass, tag compare and a per-set invalidate sweep.
module l1_cache_array_bank
    import l1_pkg::*;
#(
    parameter int SETS       = 32,
    parameter int WAYS       = 8,
    parameter int LINE_BYTES = 64,
    parameter int TAG_W      = 53,
    localparam int INDEX_W   = clog2(SETS),
    localparam int WORD_W    = clog2(LINE_BYTES / 8),
    localparam int WAY_W     = clog2(WAYS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     inv_all_i,
    output logic                     busy_o,
    input  logic                     req_valid_i,
    input  logic [INDEX_W-1:0]       req_index_i,
    input  logic [WORD_W-1:0]        req_word_i,
    input  logic [TAG_W-1:0]         req_tag_i,
    input  logic                     data_we_i,
    input  logic                     meta_we_i,
    input  logic [INDEX_W-1:0]       wr_index_i,
    input  logic [WORD_W-1:0]        wr_word_i,
    input  logic [WAY_W-1:0]         wr_way_i,
    input  logic [7:0]               wr_be_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic [1:0]               wr_state_i,
    output logic                     rvalid_o,
    output logic [WAYS*DATA_W-1:0]   rdata_way_flat_o,
    output logic [WAYS*TAG_W-1:0]    tag_way_flat_o,
    output logic [WAYS*2-1:0]        state_way_flat_o,
    output logic [WAYS-1:0]          hit_way_o,
    output logic                     hit_o
);

    localparam int WORDS  = LINE_BYTES / 8;
    localparam int ADDR_W = INDEX_W + WORD_W;

    fsm_e                  fsm_q, fsm_d;
    logic [INDEX_W-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic                  rvalid_q;
    logic [WAYS-1:0]       hit_way_q;
    logic [WAYS*DATA_W-1:0] rdata_q;
    logic [WAYS*TAG_W-1:0] tag_q;
    logic [WAYS*2-1:0]     state_q;

    logic                  idle, sweeping, rd_en, dwe, mwe;
    logic [ADDR_W-1:0]     rd_addr, wr_addr;
    logic [WAYS*DATA_W-1:0] rd_data;
    logic [WAYS*TAG_W-1:0] rd_tag;
    logic [WAYS*2-1:0]     rd_state;
    logic [WAYS-1:0]       hit_cmp;

    assign idle     = fsm_q == IDLE;
    assign sweeping = fsm_q == SWEEP;
    assign rd_en    = req_valid_i & idle;
    assign dwe      = data_we_i & idle;
    assign mwe      = meta_we_i & idle;
    assign rd_addr  = {req_index_i, req_word_i};
    assign wr_addr  = {wr_index_i, wr_word_i};

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [DATA_W-1:0] data_mem [SETS*WORDS];
        logic [TAG_W-1:0]  tag_mem [SETS];
        logic [1:0]        st_mem [SETS];
        logic              wsel;
        logic [DATA_W-1:0] old_word, merged;

        assign wsel     = wr_way_i == WAY_W'(w);
        assign old_word = data_mem[wr_addr];

        always_comb begin
            merged = old_word;
            for (int b = 0; b < 8; b++)
                if (wr_be_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
        end

        // Sweep owns the state port; normal meta writes are blocked while it runs.
        always_ff @(posedge clk_i) begin
            if (dwe && wsel) data_mem[wr_addr] <= merged;
            if (mwe && wsel) tag_mem[wr_index_i] <= wr_tag_i;
            if (sweeping) st_mem[sweep_cnt_q] <= MESI_N;
            else if (mwe && wsel) st_mem[wr_index_i] <= wr_state_i;
        end

        assign rd_data[DATA_W*w +: DATA_W] =
            (dwe && wsel && wr_addr == rd_addr) ? merged : data_mem[rd_addr];
        assign rd_tag[TAG_W*w +: TAG_W] =
            (mwe && wsel && wr_index_i == req_index_i) ? wr_tag_i : tag_mem[req_index_i];
        assign rd_state[2*w +: 2] =
            (mwe && wsel && wr_index_i == req_index_i) ? wr_state_i : st_mem[req_index_i];
    end

    l1_tag_cmp #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_tag_cmp (
        .tag_way_flat_i   (rd_tag),
        .state_way_flat_i (rd_state),
        .tag_i            (req_tag_i),
        .hit_way_o        (hit_cmp)
    );

    always_comb begin
        fsm_d       = fsm_q;
        sweep_cnt_d = sweep_cnt_q;
        if (sweeping) begin
            sweep_cnt_d = sweep_cnt_q + 1'b1;
            fsm_d       = (sweep_cnt_q == INDEX_W'(SETS - 1)) ? IDLE : SWEEP;
        end else if (inv_all_i) begin
            fsm_d       = SWEEP;
            sweep_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q       <= SWEEP;
            sweep_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            hit_way_q   <= '0;
            rdata_q     <= '0;
            tag_q       <= '0;
            state_q     <= '0;
        end else begin
            fsm_q       <= fsm_d;
            sweep_cnt_q <= sweep_cnt_d;
            rvalid_q    <= rd_en;
            hit_way_q   <= rd_en ? hit_cmp : '0;
            if (rd_en) begin
                rdata_q <= rd_data;
                tag_q   <= rd_tag;
                state_q <= rd_state;
            end
        end
    end

    assign busy_o           = sweeping;
    assign rvalid_o         = rvalid_q;
    assign rdata_way_flat_o = rdata_q;
    assign tag_way_flat_o   = tag_q;
    assign state_way_flat_o = state_q;
    assign hit_way_o        = hit_way_q;
    assign hit_o            = |hit_way_q;

endmodule
